// File: rtl/pio_bidir_irq_if.sv
// Avalon-MM slave bus bundle for the bidirectional PIO.
// The interconnect drives the master side, the PIO consumes the slave side.
interface pio_bidir_irq_if;
  logic [2:0]  address;
  logic        chipselect;
  logic        write_n;
  logic [31:0] writedata;
  logic [31:0] readdata;

  modport master (
    output address,
    output chipselect,
    output write_n,
    output writedata,
    input  readdata
  );

  modport slave (
    input  address,
    input  chipselect,
    input  write_n,
    input  writedata,
    output readdata
  );
endinterface

// File: rtl/pio_bidir_irq.sv
// Avalon-MM PIO: per-bit direction, atomic set/clear, synchronised inputs with sticky edge capture and masked irq.
// Zero wait states with combinational readdata; never stalls the bus; irq trails a pin edge by three clk edges.
module pio_bidir_irq #(
  parameter int          WIDTH       = 8,
  parameter logic [31:0] RESET_VALUE = 32'h0,
  parameter logic [31:0] DIR_RESET   = 32'h0,
  parameter int          EDGE_TYPE   = 0
) (
  input  logic               clk,
  input  logic               reset_n,
  pio_bidir_irq_if.slave     bus,
  input  logic [WIDTH-1:0]   in_port,
  output logic [WIDTH-1:0]   out_port,
  output logic [WIDTH-1:0]   out_en,
  output logic               irq
);

  localparam logic [2:0] ADDR_DATA    = 3'd0;
  localparam logic [2:0] ADDR_DIR     = 3'd1;
  localparam logic [2:0] ADDR_IRQMASK = 3'd2;
  localparam logic [2:0] ADDR_EDGECAP = 3'd3;
  localparam logic [2:0] ADDR_OUTSET  = 3'd4;
  localparam logic [2:0] ADDR_OUTCLR  = 3'd5;

  localparam logic [WIDTH-1:0] DATA_RST = RESET_VALUE[WIDTH-1:0];
  localparam logic [WIDTH-1:0] DIR_RST  = DIR_RESET[WIDTH-1:0];

  logic [WIDTH-1:0] data_out;
  logic [WIDTH-1:0] dir;
  logic [WIDTH-1:0] irqmask;
  logic [WIDTH-1:0] edgecap;
  logic [WIDTH-1:0] sync1;
  logic [WIDTH-1:0] in_sync;
  logic [WIDTH-1:0] in_prev;

  logic             wr_en;
  logic [WIDTH-1:0] wdat;
  logic [WIDTH-1:0] data_next;
  logic [WIDTH-1:0] rise;
  logic [WIDTH-1:0] fall;
  logic [WIDTH-1:0] edge_hit;
  logic [WIDTH-1:0] cap_clr;
  logic [WIDTH-1:0] cap_next;
  logic [WIDTH-1:0] rd_sel;
  logic             unused_wdata;

  assign wr_en        = bus.chipselect & ~bus.write_n;
  assign wdat         = bus.writedata[WIDTH-1:0];
  assign unused_wdata = ^bus.writedata;

  // DATA, OUTSET and OUTCLR all funnel into the one output register
  always_comb begin
    data_next = data_out;
    if (wr_en) begin
      case (bus.address)
        ADDR_DATA:   data_next = wdat;
        ADDR_OUTSET: data_next = data_out | wdat;
        ADDR_OUTCLR: data_next = data_out & ~wdat;
        default:     data_next = data_out;
      endcase
    end
  end

  always_comb begin
    rise = in_sync & ~in_prev;
    fall = ~in_sync & in_prev;
    case (EDGE_TYPE)
      0:       edge_hit = rise;
      1:       edge_hit = fall;
      default: edge_hit = rise | fall;
    endcase
  end

  // A new edge is OR-ed in after the clear so a coincident edge is never lost
  always_comb begin
    cap_clr  = (wr_en && bus.address == ADDR_EDGECAP) ? wdat : '0;
    cap_next = (edgecap & ~cap_clr) | edge_hit;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      data_out <= DATA_RST;
      dir      <= DIR_RST;
      irqmask  <= '0;
      edgecap  <= '0;
      irq      <= 1'b0;
      sync1    <= '0;
      in_sync  <= '0;
      in_prev  <= '0;
    end else begin
      data_out <= data_next;
      if (wr_en && bus.address == ADDR_DIR)     dir     <= wdat;
      if (wr_en && bus.address == ADDR_IRQMASK) irqmask <= wdat;
      edgecap  <= cap_next;
      irq      <= |(edgecap & irqmask);
      sync1    <= in_port;
      in_sync  <= sync1;
      in_prev  <= in_sync;
    end
  end

  always_comb begin
    case (bus.address)
      ADDR_DATA:    rd_sel = (dir & data_out) | (~dir & in_sync);
      ADDR_DIR:     rd_sel = dir;
      ADDR_IRQMASK: rd_sel = irqmask;
      ADDR_EDGECAP: rd_sel = edgecap;
      default:      rd_sel = '0;
    endcase
    bus.readdata              = '0;
    bus.readdata[WIDTH-1:0]   = rd_sel;
  end

  assign out_port = data_out;
  assign out_en   = dir;

endmodule

// File: tb/tb_pio_bidir_irq.sv
// Bench for pio_bidir_irq: a rising-edge and an any-edge instance share pins and bus traffic.
// Expected values are queued as stimulus is driven and compared when outputs are sampled.
module tb_pio_bidir_irq;
  localparam int W = 8;

  logic         clk = 1'b0;
  logic         reset_n;
  logic [W-1:0] pins;
  logic [W-1:0] out0, oe0, out2, oe2;
  logic         irq0, irq2;

  pio_bidir_irq_if b0 ();
  pio_bidir_irq_if b2 ();

  pio_bidir_irq #(.WIDTH(W), .RESET_VALUE(32'hA5), .DIR_RESET(32'h0F), .EDGE_TYPE(0)) dut0 (
    .clk(clk), .reset_n(reset_n), .bus(b0.slave), .in_port(pins),
    .out_port(out0), .out_en(oe0), .irq(irq0)
  );

  pio_bidir_irq #(.WIDTH(W), .RESET_VALUE(32'hA5), .DIR_RESET(32'h0F), .EDGE_TYPE(2)) dut2 (
    .clk(clk), .reset_n(reset_n), .bus(b2.slave), .in_port(pins),
    .out_port(out2), .out_en(oe2), .irq(irq2)
  );

  always #5 clk = ~clk;

  int n_pass  = 0;
  int n_total = 0;

  typedef struct {
    string       name;
    logic [31:0] val;
  } exp_t;
  exp_t sbq[$];

  typedef struct {
    logic [2:0]   addr;
    logic         is_wr;
    logic [31:0]  wdata;
    logic [W-1:0] pin;
    logic [31:0]  exp;
  } vec_t;
  localparam int NV = 16;
  vec_t vt[NV];

  task automatic expect_val(input string name, input logic [31:0] v);
    exp_t e;
    e.name = name;
    e.val  = v;
    sbq.push_back(e);
  endtask

  task automatic observe(input logic [31:0] act);
    exp_t e;
    n_total++;
    if (sbq.size() == 0) begin
      $display("FAIL scoreboard_empty actual=0x%0h required=<nothing queued>", act);
    end else begin
      e = sbq.pop_front();
      if (act === e.val) n_pass++;
      else $display("FAIL %s actual=0x%0h required=0x%0h", e.name, act, e.val);
    end
  endtask

  task automatic bus_set(input logic [2:0] a, input logic cs, input logic wn, input logic [31:0] d);
    b0.address = a;  b0.chipselect = cs; b0.write_n = wn; b0.writedata = d;
    b2.address = a;  b2.chipselect = cs; b2.write_n = wn; b2.writedata = d;
  endtask

  task automatic wr(input logic [2:0] a, input logic [31:0] d);
    @(posedge clk); #1;
    bus_set(a, 1'b1, 1'b0, d);
    @(posedge clk); #1;
    bus_set(a, 1'b1, 1'b1, 32'h0);
  endtask

  task automatic rd_setup(input logic [2:0] a);
    @(posedge clk); #1;
    bus_set(a, 1'b1, 1'b1, 32'h0);
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout actual=running required=finished");
    $fatal(1, "watchdog expired");
  end

  initial begin
    vt[0]  = '{3'd1, 1'b1, 32'h0000_00F0, 8'h0C, 32'hA5};
    vt[1]  = '{3'd0, 1'b1, 32'h0000_003A, 8'h0C, 32'h3A};
    vt[2]  = '{3'd0, 1'b0, 32'h0,         8'h0C, 32'h3C};
    vt[3]  = '{3'd4, 1'b1, 32'h0000_0005, 8'h0C, 32'h3F};
    vt[4]  = '{3'd5, 1'b1, 32'h0000_0030, 8'h0C, 32'h0F};
    vt[5]  = '{3'd1, 1'b0, 32'h0,         8'h0C, 32'hF0};
    vt[6]  = '{3'd4, 1'b0, 32'h0,         8'h0C, 32'h00};
    vt[7]  = '{3'd5, 1'b0, 32'h0,         8'h0C, 32'h00};
    vt[8]  = '{3'd7, 1'b1, 32'h0000_00FF, 8'h0C, 32'h0F};
    vt[9]  = '{3'd6, 1'b0, 32'h0,         8'h0C, 32'h00};
    vt[10] = '{3'd2, 1'b1, 32'h0000_005A, 8'h0C, 32'h0F};
    vt[11] = '{3'd2, 1'b0, 32'h0,         8'h0C, 32'h5A};
    vt[12] = '{3'd3, 1'b0, 32'h0,         8'h0C, 32'h0C};
    vt[13] = '{3'd0, 1'b1, 32'hFFFF_FF81, 8'h0C, 32'h81};
    vt[14] = '{3'd0, 1'b0, 32'h0,         8'h0C, 32'h8C};
    vt[15] = '{3'd7, 1'b0, 32'h0,         8'h0C, 32'h00};

    reset_n = 1'b0;
    pins    = '0;
    bus_set(3'd0, 1'b0, 1'b1, 32'h0);
    #23 reset_n = 1'b1;

    // Reset state
    expect_val("rst_out_port", 32'hA5);
    expect_val("rst_out_en",   32'h0F);
    expect_val("rst_irq",      32'h0);
    expect_val("rst_out_port_any", 32'hA5);
    idle(1);
    observe(32'(out0));
    observe(32'(oe0));
    observe(32'(irq0));
    observe(32'(out2));
    expect_val("rst_edgecap", 32'h0);
    rd_setup(3'd3);
    observe(b0.readdata);

    // Register vectors
    for (int i = 0; i < NV; i++) begin
      pins = vt[i].pin;
      expect_val($sformatf("vec%0d_rise_inst", i), vt[i].exp);
      expect_val($sformatf("vec%0d_any_inst", i), vt[i].exp);
      if (vt[i].is_wr) begin
        wr(vt[i].addr, vt[i].wdata);
        observe(32'(out0));
        observe(32'(out2));
      end else begin
        rd_setup(vt[i].addr);
        observe(b0.readdata);
        observe(b2.readdata);
      end
    end

    // Rising edge to capture and irq latency
    wr(3'd2, 32'h0);
    pins = '0;
    idle(4);
    wr(3'd3, 32'hFF);
    wr(3'd2, 32'h01);
    bus_set(3'd3, 1'b1, 1'b1, 32'h0);
    pins[0] = 1'b1;
    for (int j = 0; j < 4; j++) begin
      expect_val($sformatf("lat_edgecap_E+%0d", j), (j >= 2) ? 32'h1 : 32'h0);
      expect_val($sformatf("lat_irq_E+%0d", j), (j >= 3) ? 32'h1 : 32'h0);
      @(posedge clk); #1;
      observe(b0.readdata);
      observe(32'(irq0));
    end
    bus_set(3'd3, 1'b1, 1'b0, 32'h01);
    expect_val("clr_irq_at_C", 32'h1);
    expect_val("clr_edgecap_at_C", 32'h0);
    expect_val("clr_irq_at_C+1", 32'h0);
    @(posedge clk); #1;
    bus_set(3'd3, 1'b1, 1'b1, 32'h0);
    observe(32'(irq0));
    @(negedge clk);
    observe(b0.readdata);
    @(posedge clk); #1;
    observe(32'(irq0));

    // Edge and write-1-to-clear on the same bit in the same cycle
    pins[2] = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    bus_set(3'd3, 1'b1, 1'b0, 32'h04);
    @(posedge clk); #1;
    bus_set(3'd3, 1'b1, 1'b1, 32'h0);
    expect_val("coincident_set_wins", 32'h04);
    expect_val("coincident_sticky", 32'h04);
    expect_val("plain_clear", 32'h00);
    @(negedge clk);
    observe(b0.readdata);
    idle(2);
    observe(b0.readdata);
    wr(3'd3, 32'h04);
    @(negedge clk);
    observe(b0.readdata);

    // Any-edge capture with irq masked off
    wr(3'd2, 32'h0);
    wr(3'd3, 32'hFF);
    for (int t = 0; t < 2; t++) begin
      pins[5] = ~pins[5];
      idle(4);
      expect_val($sformatf("any_cap_t%0d", t), 32'h20);
      expect_val($sformatf("any_irq_t%0d", t), 32'h0);
      expect_val($sformatf("rise_only_t%0d", t), (t == 0) ? 32'h20 : 32'h0);
      rd_setup(3'd3);
      observe(b2.readdata);
      observe(32'(irq2));
      observe(b0.readdata);
      wr(3'd3, 32'h20);
      expect_val($sformatf("any_cleared_t%0d", t), 32'h0);
      expect_val($sformatf("any_irq_after_clr_t%0d", t), 32'h0);
      @(negedge clk);
      observe(b2.readdata);
      observe(32'(irq2));
    end

    // Asynchronous reset with captures and irq pending
    pins = '0;
    idle(4);
    wr(3'd3, 32'hFF);
    pins = 8'hFF;
    idle(4);
    wr(3'd2, 32'hFF);
    wr(3'd0, 32'h12);
    expect_val("pre_rst_edgecap_rise", 32'hFF);
    expect_val("pre_rst_edgecap_any",  32'hFF);
    expect_val("pre_rst_irq_rise", 32'h1);
    expect_val("pre_rst_irq_any",  32'h1);
    expect_val("pre_rst_out_port", 32'h12);
    rd_setup(3'd3);
    observe(b0.readdata);
    observe(b2.readdata);
    observe(32'(irq0));
    observe(32'(irq2));
    observe(32'(out0));
    #2 reset_n = 1'b0;
    expect_val("arst_irq_rise", 32'h0);
    expect_val("arst_irq_any",  32'h0);
    expect_val("arst_out_port", 32'hA5);
    expect_val("arst_out_en",   32'h0F);
    expect_val("arst_edgecap",  32'h0);
    expect_val("arst_irqmask",  32'h0);
    #1;
    observe(32'(irq0));
    observe(32'(irq2));
    observe(32'(out0));
    observe(32'(oe0));
    observe(b0.readdata);
    bus_set(3'd2, 1'b1, 1'b1, 32'h0);
    #1;
    observe(b0.readdata);
    @(negedge clk);
    reset_n = 1'b1;
    idle(4);
    expect_val("post_rst_rise_capture", 32'hFF);
    expect_val("post_rst_irq_masked", 32'h0);
    rd_setup(3'd3);
    observe(b0.readdata);
    observe(32'(irq0));

    if (sbq.size() != 0) begin
      n_total++;
      $display("FAIL scoreboard_leftover actual=%0d required=0", sbq.size());
    end
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule

// File: doc/pio_bidir_irq.md
# pio_bidir_irq

Parametrised Avalon-MM parallel I/O port, the successor to the fixed 1-bit output-only PIO used for start/control signals. It provides WIDTH bits with per-bit direction and atomic set/clear of output bits. Inputs pass through a two-flop synchroniser and feed sticky edge capture with a maskable, registered interrupt. It sits on the system interconnect as an Avalon-MM slave with zero wait states and drives board pins or neighbouring logic.

## Interface
- WIDTH, 8, number of I/O bits (1..32)
- RESET_VALUE, 0, reset value of the output data register (WIDTH bits)
- DIR_RESET, 0, reset value of the direction register; bit = 1 means output
- EDGE_TYPE, 0, edge capture mode: 0 rising, 1 falling, 2 any

Ports:
- clk  in  1  single clock; all state is on its rising edge
- reset_n  in  1  asynchronous, active-low reset
- address  in  3  register select
- chipselect  in  1  slave select
- write_n  in  1  active-low write strobe
- writedata  in  32  write data; bits [WIDTH-1:0] used, upper bits ignored
- readdata  out  32  combinational read data, zero-extended above WIDTH
- in_port  in  WIDTH  asynchronous pin inputs
- out_port  out  WIDTH  output data register
- out_en  out  WIDTH  direction register (pin output enable)
- irq  out  1  registered, level-high interrupt

## Operation
- Register map (word address):
  - 0 DATA: write loads data_out. Read returns per bit dir ? data_out : in_sync.
  - 1 DIR: read/write.
  - 2 IRQMASK: read/write.
  - 3 EDGECAP: read returns capture bits; writing 1 clears a bit, writing 0 leaves it.
  - 4 OUTSET: write ORs writedata into data_out; reads 0.
  - 5 OUTCLR: write clears data_out bits where writedata = 1; reads 0.
  - 6–7: reads 0, writes ignored.
- A write occurs when chipselect = 1 and write_n = 0. A read has no side effects; EDGECAP is never read-cleared.
- Synchroniser: sync1 <= in_port, in_sync <= sync1, in_prev <= in_sync.
- Edge detection: rise = in_sync & ~in_prev, fall = ~in_sync & in_prev. EDGE_TYPE selects rise, fall, or rise | fall.
- Edge detection runs on all bits regardless of DIR.
- EDGECAP bit set: sticky.
- Same-cycle edge and write-1-to-clear on one bit: the set wins and the bit stays 1.
- irq <= |(edgecap & irqmask), registered.
- Reset (asynchronous, any time, including mid-operation):
  - data_out = RESET_VALUE, dir = DIR_RESET.
  - irqmask = 0, edgecap = 0, irq = 0.
  - sync1, in_sync and in_prev = 0. A pin held high through reset therefore produces a rising edge after release.
- out_port = data_out and out_en = dir at all times. Bits with dir = 0 still hold data_out.

## Timing
- Zero wait states; readdata is valid in the same cycle as address/chipselect.
- A register write takes effect at the clk edge that samples it. out_port changes at that edge.
- in_port change before edge E:
  - in_sync updates at edge E+1 (DATA read reflects it after E+1).
  - edgecap bit sets at E+2.
  - irq asserts at E+3 if the mask bit is set.
- Clearing the last pending capture bit at edge C drops irq at edge C+1. Clearing a mask bit behaves the same way.
- Setting a mask bit over an already-set capture bit raises irq one edge after the mask write.
- Input pulses shorter than one clk period may be missed; this is by design.

## Test plan
- Reset with WIDTH=8, RESET_VALUE=0xA5, DIR_RESET=0x0F.
  - Required after reset: out_port = 0xA5, out_en = 0x0F, irq = 0.
  - Read of address 3 returns 0.
- DIR=0xF0, in_port=0x0C, DATA=0x3A. Read address 0 returns 0x3C. Then:
  - OUTSET 0x05 -> out_port 0x3F.
  - OUTCLR 0x30 -> out_port 0x0F.
- EDGE_TYPE=0, IRQMASK=0x01, in_port bit0 0->1 before edge E:
  - edgecap = 0x01 at E+2, irq = 1 at E+3.
  - Then write 0x01 to address 3: irq = 0 one edge after the write.
- Simultaneous case: a rising edge on bit 2 lands in the same cycle as an EDGECAP clear write of 0x04. Required: bit 2 stays set and the read returns 0x04.
- EDGE_TYPE=2 with bit 5 toggling 0->1->0, separated by more than 3 cycles:
  - bit 5 captured each time; clear works between toggles.
  - With IRQMASK = 0, irq stays 0 throughout.
- Assert reset_n low mid-operation while edgecap = 0xFF and irq = 1. Required: irq, edgecap and mask go to 0 immediately (asynchronously), and out_port returns to RESET_VALUE.
